keypad_scanner: RTL



---
 rtl/keypad_if.sv | 10 +
 rtl/keypad_scanner.sv | 94 +++++++++
 2 files changed

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix pins plus the token stream toward the calculator.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] token;
    logic       token_valid;
    logic       key_down;
    modport master(input row, output col, output token, output token_valid, output key_down);
    modport slave(output row, input col, input token, input token_valid, input key_down);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces whole scans and emits one token per press.
module keypad_scanner #(
    parameter int COL_TICKS      = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kp
);
    localparam int TW = $clog2(COL_TICKS);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [1:0] NONE = 2'd0, ONE = 2'd1, MULTI = 2'd2;
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    typedef enum logic {IDLE, HELD} state_t;

    state_t          state, state_n;
    logic [3:0]      row_m, row_s;
    logic [TW-1:0]   tick;
    logic [1:0]      idx;
    logic [1:0]      acc_cnt, acc_cnt_n;
    logic [3:0]      acc_code, acc_code_n;
    logic [1:0]      prev_kind;
    logic [3:0]      prev_code;
    logic [SW-1:0]   stable, stable_n;
    logic [3:0]      low;
    logic [2:0]      n_low, sum;
    logic [1:0]      hit_row;
    logic            sample, scan_end, same, settled, report, release_key;

    // acc_cnt doubles as the scan-result kind: 0 = NONE, 1 = ONE, 2 = MULTI (saturated)
    always_comb begin
        low         = ~row_s;
        n_low       = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        hit_row     = low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
        sum         = 3'(acc_cnt) + n_low;
        acc_cnt_n   = sum > 3'd1 ? MULTI : sum[1:0];
        acc_code_n  = n_low != 3'd0 ? KEY_MAP[{idx, hit_row}] : acc_code;
        sample      = tick == TW'(COL_TICKS - 1);
        scan_end    = sample && idx == 2'd3;
        same        = acc_cnt_n == prev_kind && (acc_cnt_n != ONE || acc_code_n == prev_code);
        stable_n    = !same ? SW'(1) : stable == SW'(DEBOUNCE_SCANS) ? stable : stable + SW'(1);
        settled     = scan_end && stable_n == SW'(DEBOUNCE_SCANS);
        report      = settled && state == IDLE && acc_cnt_n == ONE;
        release_key = settled && state == HELD && acc_cnt_n == NONE;
        state_n     = report ? HELD : release_key ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_m          <= 4'hF;
            row_s          <= 4'hF;
            tick           <= '0;
            idx            <= 2'd0;
            kp.col         <= 4'b1110;
            acc_cnt        <= NONE;
            acc_code       <= 4'h0;
            prev_kind      <= NONE;
            prev_code      <= 4'h0;
            stable         <= '0;
            kp.token       <= 4'h0;
            kp.token_valid <= 1'b0;
        end else begin
            row_m          <= kp.row;
            row_s          <= row_m;
            tick           <= sample ? '0 : tick + TW'(1);
            kp.token_valid <= report;
            if (report) kp.token <= acc_code_n;
            if (sample) begin
                idx      <= idx + 2'd1;
                kp.col   <= ~(4'b0001 << (idx + 2'd1));
                acc_cnt  <= scan_end ? NONE : acc_cnt_n;
                acc_code <= scan_end ? 4'h0 : acc_code_n;
            end
            if (scan_end) begin
                prev_kind <= acc_cnt_n;
                prev_code <= acc_code_n;
                stable    <= stable_n;
            end
        end
    end

    assign kp.key_down = state == HELD;
endmodule
